key_expansion_seq: RTL

//  Sequential AES-128 key schedule. Expands a 128-bit cipher key into the 44-word (1408-bit)

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_sbox.sv | 12 +
 rtl/key_expansion_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, key-schedule constants and
// expansion FSM state encoding.
package aes_pkg;

    localparam int          NW        = 44;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RED_POLY  = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports: a = input byte, y = substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule, one word per clock into a 44-word bus.
// Ports: clk, rst_n, start, key[127:0] in; busy, w_valid, w[1407:0] out.
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NK*32-1:0]         key,
    output logic                     busy,
    output logic                     w_valid,
    output logic [4*(NR+1)*32-1:0]   w
);

    localparam int         NWL      = 4 * (NR + 1);
    localparam logic [5:0] LAST_IDX = 6'(NWL - 1);

    state_e               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [7:0]           rcon_q, rcon_d;
    logic [NWL*32-1:0]    w_q, w_d;

    logic [5:0]           idx_m1, idx_m4;
    logic [31:0]          prev_word, back_word;
    logic [31:0]          rot_word, sub_word, temp, new_word;
    logic [NWL-1:0]       we;
    logic [127:0]         load_w;

    assign idx_m1    = idx_q - 6'd1;
    assign idx_m4    = idx_q - 6'd4;
    assign prev_word = w_q[{idx_m1, 5'd0} +: 32];
    assign back_word = w_q[{idx_m4, 5'd0} +: 32];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_word[8*b +: 8]),
            .y (sub_word[8*b +: 8])
        );
    end

    // Every fourth word takes the RotWord/SubWord/rcon path.
    assign temp     = (idx_q[1:0] == 2'd0)
                    ? (sub_word ^ {rcon_q, 24'h0})
                    : prev_word;
    assign new_word = back_word ^ temp;

    // Key byte 0 lands in the top byte of word 0.
    always_comb begin
        load_w = '0;
        for (int i = 0; i < 4; i++) begin
            load_w[32*i +: 32] = {key[32*i +: 8],
                                  key[32*i+8 +: 8],
                                  key[32*i+16 +: 8],
                                  key[32*i+24 +: 8]};
        end
    end

    always_comb begin
        we = '0;
        if (state_q == ST_EXPAND) begin
            we[idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_EXPAND;
                    idx_d       = 6'd4;
                    rcon_d      = RCON_INIT;
                    w_d         = '0;
                    w_d[127:0]  = load_w;
                end
            end
            ST_EXPAND: begin
                for (int j = 0; j < NWL; j++) begin
                    if (we[j]) begin
                        w_d[32*j +: 32] = new_word;
                    end
                end
                if (idx_q[1:0] == 2'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            w_q     <= w_d;
        end
    end

    assign busy    = (state_q == ST_EXPAND);
    assign w_valid = (state_q == ST_DONE);
    assign w       = w_q;

endmodule
